// File: rtl/mem_responder.sv
// Two-port byte-serial memory responder: serves one 32-bit read or write request
// at a time from an instruction port and a data port over an 8-bit synchronous RAM.
module mem_responder #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mem_rwe_i,
  input  logic [63:0]           mem_addr_i,
  input  logic [7:0]            mem_sel_i,
  input  logic [63:0]           mem_data_i,
  output logic [63:0]           mem_data_o,
  output logic [1:0]            mem_busy_o,
  output logic [1:0]            mem_done_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_wdata_o,
  input  logic [7:0]            ram_rdata_i,
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic                  port;
  logic                  last;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-3:0] word;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [23:0]           rbuf;

  logic [1:0]  elig;
  logic        pick;
  logic [1:0]  acc_rwe;
  logic [31:0] acc_addr;
  logic [3:0]  acc_sel;
  logic [31:0] acc_data;
  logic [1:0]  nxt;

  // A port whose done is still showing is not eligible; alternate on contention.
  assign elig[0]  = (|mem_rwe_i[1:0]) && !mem_done_o[0];
  assign elig[1]  = (|mem_rwe_i[3:2]) && !mem_done_o[1];
  assign pick     = (elig == 2'b11) ? ~last : elig[1];
  assign acc_rwe  = pick ? mem_rwe_i[3:2]    : mem_rwe_i[1:0];
  assign acc_addr = pick ? mem_addr_i[63:32] : mem_addr_i[31:0];
  assign acc_sel  = pick ? mem_sel_i[7:4]    : mem_sel_i[3:0];
  assign acc_data = pick ? mem_data_i[63:32] : mem_data_i[31:0];
  assign nxt      = cnt[1:0] + 2'd1;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      port        <= 1'b0;
      last        <= 1'b1;
      cnt         <= 3'd0;
      word        <= '0;
      sel_q       <= 4'd0;
      wdata_q     <= 32'd0;
      rbuf        <= 24'd0;
      mem_busy_o  <= 2'b00;
      mem_done_o  <= 2'b00;
      mem_data_o  <= 64'd0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|elig) begin
            port       <= pick;
            last       <= pick;
            word       <= acc_addr[ADDR_WIDTH-1:2];
            sel_q      <= acc_sel;
            wdata_q    <= acc_data;
            cnt        <= 3'd0;
            mem_busy_o <= pick ? 2'b10 : 2'b01;
            ram_addr_o <= {acc_addr[ADDR_WIDTH-1:2], 2'b00};
            // Byte 0 goes out on the acceptance edge so each access is exactly 4 RAM cycles.
            if (acc_rwe[1]) begin
              state       <= S_WRITE;
              ram_en_o    <= acc_sel[0];
              ram_we_o    <= acc_sel[0];
              ram_wdata_o <= acc_data[7:0];
            end else begin
              state    <= S_READ;
              ram_en_o <= 1'b1;
              ram_we_o <= 1'b0;
            end
          end
        end
        S_READ: begin
          cnt <= cnt + 3'd1;
          if (cnt < 3'd3) begin
            ram_addr_o <= {word, nxt};
            ram_en_o   <= 1'b1;
          end else begin
            ram_en_o <= 1'b0;
          end
          // The byte issued in the previous cycle is on ram_rdata_i now.
          case (cnt)
            3'd1: rbuf[7:0]   <= ram_rdata_i;
            3'd2: rbuf[15:8]  <= ram_rdata_i;
            3'd3: rbuf[23:16] <= ram_rdata_i;
            3'd4: begin
              if (port) mem_data_o[63:32] <= {ram_rdata_i, rbuf};
              else      mem_data_o[31:0]  <= {ram_rdata_i, rbuf};
              mem_done_o <= port ? 2'b10 : 2'b01;
              mem_busy_o <= 2'b00;
              state      <= S_DONE;
            end
            default: ;
          endcase
        end
        S_WRITE: begin
          cnt <= cnt + 3'd1;
          if (cnt < 3'd3) begin
            ram_addr_o  <= {word, nxt};
            ram_en_o    <= sel_q[nxt];
            ram_we_o    <= sel_q[nxt];
            ram_wdata_o <= wdata_q[8*nxt +: 8];
          end else begin
            ram_en_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            mem_done_o <= port ? 2'b10 : 2'b01;
            mem_busy_o <= 2'b00;
            state      <= S_DONE;
          end
        end
        default: begin
          mem_done_o <= 2'b00;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: byte RAM model, directed vector table, multi-cycle
// corner sequences and randomized requests against a word-level memory model.
module tb_mem_responder;
  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    rwe = 4'd0;
  logic [63:0]   addr = 64'd0;
  logic [7:0]    sel = 8'd0;
  logic [63:0]   wdata = 64'd0;
  logic [63:0]   data_o;
  logic [1:0]    busy;
  logic [1:0]    done;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = 8'd0;
  logic [1:0]    fsm_state;

  logic [7:0]  ram [DEPTH];
  logic [7:0]  mm  [DEPTH];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd [2];
  logic [31:0] exp_q [$];

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_rwe_i(rwe), .mem_addr_i(addr), .mem_sel_i(sel), .mem_data_i(wdata),
    .mem_data_o(data_o), .mem_busy_o(busy), .mem_done_o(done),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .fsm_state(fsm_state)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr] <= ram_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic preset(input int a, input logic [7:0] v);
    ram[a] = v;
    mm[a]  = v;
  endtask

  function automatic int base_of(input logic [31:0] a);
    return int'(a[AW-1:0]) & ~3;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = base_of(a);
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  // One request on port p; hold keeps rwe high through the done cycle.
  task automatic do_req(input int p, input bit wr, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_rd, input bit hold);
    int   nb;
    bit   got;
    int   wc0;
    int   b;
    logic [31:0] e;
    @(negedge clk);
    wc0 = wr_cnt;
    addr[32*p +: 32]  = a;
    sel[4*p +: 4]     = s;
    wdata[32*p +: 32] = d;
    rwe[2*p +: 2]     = wr ? (($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10) : 2'b01;
    if (!wr) exp_q.push_back(exp_rd);
    @(negedge clk);
    chk("accept_busy", {62'd0, busy}, (p == 1) ? 64'd2 : 64'd1);
    addr[32*p +: 32]  = $urandom();
    sel[4*p +: 4]     = 4'($urandom_range(0, 15));
    wdata[32*p +: 32] = $urandom();
    nb  = 1;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done[p]) begin
        got = 1;
        break;
      end
      if (busy[p]) nb++;
    end
    chk("done_seen", {63'd0, got}, 64'd1);
    chk("latency", 64'(nb), wr ? 64'd4 : 64'd5);
    chk("busy_in_done", {62'd0, busy}, 64'd0);
    chk("ram_idle_in_done", {62'd0, ram_en, ram_we}, 64'd0);
    if (!wr) begin
      e = exp_q.pop_front();
      chk("rdata", {32'd0, data_o[32*p +: 32]}, {32'd0, e});
      last_rd[p] = e;
    end
    chk("other_port_data", {32'd0, data_o[32*(1-p) +: 32]}, {32'd0, last_rd[1-p]});
    if (hold) begin
      @(posedge clk);
      #1;
    end
    rwe[2*p +: 2] = 2'b00;
    if (wr) begin
      b = base_of(a);
      for (int i = 0; i < 4; i++)
        if (s[i]) mm[b+i] = d[8*i +: 8];
      chk("ram_word", {32'd0, ram[b+3], ram[b+2], ram[b+1], ram[b]}, {32'd0, model_word(a)});
      chk("write_count", 64'(wr_cnt - wc0), 64'($countones(s)));
    end else begin
      chk("read_no_write", 64'(wr_cnt - wc0), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy_done"}, {60'd0, busy, done}, 64'd0);
    chk({tag, "_data"}, data_o, 64'd0);
    chk({tag, "_ram"}, {37'd0, ram_en, ram_we, ram_addr, ram_wdata}, 64'd0);
    chk({tag, "_state"}, {62'd0, fsm_state}, 64'd0);
  endtask

  initial begin
    int   wc0;
    bit   got;
    logic [31:0] e0;
    logic [31:0] e1;

    for (int i = 0; i < DEPTH; i++) preset(i, 8'($urandom()));
    preset(32'h100, 8'h11); preset(32'h101, 8'h22); preset(32'h102, 8'h33); preset(32'h103, 8'h44);
    preset(32'h200, 8'h00); preset(32'h201, 8'h01); preset(32'h202, 8'h02); preset(32'h203, 8'h03);
    preset(32'h300, 8'h10); preset(32'h301, 8'h20); preset(32'h302, 8'h30); preset(32'h303, 8'h40);
    preset(32'h1FFFC, 8'h5A); preset(32'h1FFFD, 8'h6B); preset(32'h1FFFE, 8'h7C); preset(32'h1FFFF, 8'h8D);
    preset(32'h400, 8'hA0); preset(32'h401, 8'hA1); preset(32'h402, 8'hA2); preset(32'h403, 8'hA3);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    vecs[0] = '{0, 1'b0, 32'h0000_0102, 4'h0, 32'h0,         32'h4433_2211};
    vecs[1] = '{0, 1'b1, 32'h0000_0200, 4'h5, 32'hAABB_CCDD, 32'h0};
    vecs[2] = '{1, 1'b0, 32'h0000_0203, 4'h0, 32'h0,         32'h03BB_01DD};
    vecs[3] = '{1, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h8D7C_6B5A};
    vecs[4] = '{0, 1'b1, 32'h0000_0300, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{0, 1'b0, 32'h0000_0301, 4'h0, 32'h0,         32'h4030_2010};
    vecs[6] = '{1, 1'b1, 32'h0001_FFFF, 4'hF, 32'h1234_5678, 32'h0};
    vecs[7] = '{0, 1'b0, 32'h7FFF_FFFD, 4'h0, 32'h0,         32'h1234_5678};

    // Reset
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Contention right after reset: port 0 first, port 1 waits without busy.
    @(negedge clk);
    e0 = model_word(32'h500);
    e1 = model_word(32'h600);
    addr = {32'h600, 32'h500};
    rwe  = 4'b0101;
    @(negedge clk);
    chk("both_first_busy", {62'd0, busy}, 64'd1);
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done[0]) begin
        got = 1;
        break;
      end
      chk("both_wait_busy1", {63'd0, busy[1]}, 64'd0);
      chk("both_wait_done1", {63'd0, done[1]}, 64'd0);
    end
    chk("both_done0", {63'd0, got}, 64'd1);
    chk("both_data0", {32'd0, data_o[31:0]}, {32'd0, e0});
    last_rd[0] = e0;
    rwe[1:0] = 2'b00;
    @(negedge clk);
    chk("both_idle_gap", {62'd0, busy}, 64'd0);
    @(negedge clk);
    chk("both_second_busy", {62'd0, busy}, 64'd2);
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done[1]) begin
        got = 1;
        break;
      end
    end
    chk("both_done1", {63'd0, got}, 64'd1);
    chk("both_data1", {32'd0, data_o[63:32]}, {32'd0, e1});
    chk("both_data0_kept", {32'd0, data_o[31:0]}, {32'd0, e0});
    last_rd[1] = e1;
    rwe[3:2] = 2'b00;

    // Directed vector table
    for (int i = 0; i < 8; i++)
      do_req(vecs[i].port, vecs[i].wr, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].exp_rd, 1'b0);

    // rwe held through the done cycle: one access only.
    wc0 = wr_cnt;
    do_req(0, 1'b1, 32'h700, 4'b1011, $urandom(), 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    chk("hold_no_reaccept", {62'd0, busy}, 64'd0);
    chk("hold_write_count", 64'(wr_cnt - wc0), 64'd3);

    // Reset during a full-word write after byte 1 is on the bus.
    wc0 = wr_cnt;
    @(negedge clk);
    addr[31:0]  = 32'h400;
    sel[3:0]    = 4'hF;
    wdata[31:0] = 32'hCAFE_F00D;
    rwe[1:0]    = 2'b10;
    @(negedge clk);
    chk("rstmid_busy", {62'd0, busy}, 64'd1);
    rwe[1:0] = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rstmid");
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstmid_no_done", {60'd0, busy, done}, 64'd0);
    end
    chk("rstmid_ram", {32'd0, ram[32'h403], ram[32'h402], ram[32'h401], ram[32'h400]}, 64'hA3A2_F00D);
    chk("rstmid_write_count", 64'(wr_cnt - wc0), 64'd2);
    mm[32'h400] = 8'h0D;
    mm[32'h401] = 8'hF0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    // Randomized requests against the word-level model
    for (int n = 0; n < 40; n++) begin
      int          p;
      bit          w;
      logic [31:0] a;
      p = $urandom_range(0, 1);
      w = ($urandom_range(0, 1) != 0);
      a = $urandom();
      do_req(p, w, a, 4'($urandom_range(0, 15)), $urandom(), model_word(a), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
